// File: rtl/sal_axi_pkg.sv
// Shared definitions for the SAL AXI front-end blocks.
// Holds default bus widths, AXI response and burst codes, and the
// byte offsets of the APB-visible registers of the AW/B front end.
package sal_axi_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [11:0] REG_CTRL    = 12'h000;
    localparam logic [11:0] REG_BASE    = 12'h004;
    localparam logic [11:0] REG_LIMIT   = 12'h008;
    localparam logic [11:0] REG_STATUS  = 12'h00C;
    localparam logic [11:0] REG_ERR_CNT = 12'h010;

    function automatic logic reg_is_mapped(input logic [11:0] off);
        return (off == REG_CTRL) || (off == REG_BASE) || (off == REG_LIMIT) ||
               (off == REG_STATUS) || (off == REG_ERR_CNT);
    endfunction

endpackage

// File: rtl/sal_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_wdata       write strobe and data (ignored when full)
//   i_pop                 read strobe (ignored when empty)
//   o_rdata               head entry (valid when !o_empty)
//   o_full, o_empty       occupancy flags
//   o_count               number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/sal_axi_aw_b_front.sv
// AXI write-address / write-response front end of the DDR2 controller.
// Screens AW requests against an APB-programmed address window, queues
// them in order, forwards legal ones to the scheduler and returns one B
// response per accepted AW in acceptance order.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_psel..i_pwdata, o_pready..o_pslverr APB register port
//   i_aw*, o_awready                     AXI write-address channel
//   o_bvalid, i_bready, o_bid, o_bresp   AXI write-response channel
//   o_cmd_*, i_cmd_ready                 command port to the scheduler
module sal_axi_aw_b_front
    import sal_axi_pkg::*;
#(
    parameter int ID_WIDTH   = ID_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [11:0]           i_paddr,
    input  logic [31:0]           i_pwdata,
    output logic                  o_pready,
    output logic [31:0]           o_prdata,
    output logic                  o_pslverr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [ID_WIDTH-1:0]   i_awid,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [ID_WIDTH-1:0]   o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ID_WIDTH-1:0]   o_cmd_id,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [7:0]            o_cmd_len,
    output logic [2:0]            o_cmd_size,
    output logic [1:0]            o_cmd_burst
);
    localparam int ENT_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  r_enable;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_limit;
    logic [31:0]           r_err_cnt;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;

    logic                  w_access;
    logic                  w_wr;
    logic [31:0]           w_rdata;
    logic                  w_aw_hs;
    logic                  w_aw_err;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [ENT_W-1:0]      w_push_data;
    logic [ENT_W-1:0]      w_head;
    logic                  w_h_err;
    logic                  w_b_free;
    logic                  w_pop;

    // ---------------- APB register port ----------------
    assign w_access  = i_psel && i_penable;
    assign o_pready  = 1'b1;
    assign o_pslverr = w_access &&
                       (!reg_is_mapped(i_paddr) || (i_pwrite && (i_paddr == REG_STATUS)));
    assign w_wr      = w_access && i_pwrite && !o_pslverr;

    always_comb begin
        w_rdata = '0;
        case (i_paddr)
            REG_CTRL:    w_rdata = {31'b0, r_enable};
            REG_BASE:    w_rdata = 32'(r_base);
            REG_LIMIT:   w_rdata = 32'(r_limit);
            REG_STATUS:  w_rdata = 32'(w_count) | (32'(r_bvalid) << 8);
            REG_ERR_CNT: w_rdata = r_err_cnt;
            default:     w_rdata = '0;
        endcase
    end

    assign o_prdata = (w_access && !i_pwrite) ? w_rdata : '0;

    // ---------------- AW screening and queueing ----------------
    // Reset gating keeps awready low while r_enable sits at its reset value of 1.
    assign o_awready   = r_enable && !w_full && !i_rst;
    assign w_aw_hs     = i_awvalid && o_awready;
    assign w_aw_err    = (i_awaddr < r_base) || (i_awaddr > r_limit) ||
                         (i_awburst == BURST_RSVD);
    assign w_push_data = {i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, w_aw_err};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable  <= 1'b1;
            r_base    <= '0;
            r_limit   <= '1;
            r_err_cnt <= '0;
        end else begin
            if (w_wr && (i_paddr == REG_CTRL))  r_enable <= i_pwdata[0];
            if (w_wr && (i_paddr == REG_BASE))  r_base   <= ADDR_WIDTH'(i_pwdata);
            if (w_wr && (i_paddr == REG_LIMIT)) r_limit  <= ADDR_WIDTH'(i_pwdata);
            // A clearing write takes priority over a same-cycle increment.
            if (w_wr && (i_paddr == REG_ERR_CNT))
                r_err_cnt <= '0;
            else if (w_aw_hs && w_aw_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    sal_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_aw_hs),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ---------------- head retire and B stage ----------------
    assign {o_cmd_id, o_cmd_addr, o_cmd_len, o_cmd_size, o_cmd_burst, w_h_err} = w_head;

    // The command is only offered when its response slot is guaranteed,
    // so a scheduler handshake always retires the head.
    assign w_b_free    = !r_bvalid || i_bready;
    assign o_cmd_valid = !w_empty && !w_h_err && w_b_free;
    assign w_pop       = !w_empty && w_b_free && (w_h_err || i_cmd_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bvalid <= 1'b0;
        end else if (w_pop) begin
            r_bvalid <= 1'b1;
        end else if (i_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            r_bid   <= o_cmd_id;
            r_bresp <= w_h_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign o_bvalid = r_bvalid;
    assign o_bid    = r_bid;
    assign o_bresp  = r_bresp;

endmodule

// File: tb/tb_sal_axi_aw_b_front.sv
module tb_sal_axi_aw_b_front;
    localparam int IDW = 4;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [11:0]   paddr;
    logic [31:0]   pwdata;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic          awvalid, awready;
    logic [IDW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          bvalid, bready;
    logic [IDW-1:0] bid;
    logic [1:0]    bresp;
    logic          cmd_valid, cmd_ready;
    logic [IDW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;

    int checks = 0;
    int errors = 0;

    logic [5:0] bq[$];
    logic [3:0] cq[$];

    always #5 clk = ~clk;

    sal_axi_aw_b_front #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite), .i_paddr(paddr),
        .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
        .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awaddr(awaddr),
        .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
        .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_id(cmd_id),
        .o_cmd_addr(cmd_addr), .o_cmd_len(cmd_len), .o_cmd_size(cmd_size),
        .o_cmd_burst(cmd_burst)
    );

    // Record completed handshakes; sampled at the edge with pre-edge values.
    always @(posedge clk) begin
        if (!rst) begin
            if (bvalid && bready)      bq.push_back({bid, bresp});
            if (cmd_valid && cmd_ready) cq.push_back(cmd_id);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst);
        awid    = id;
        awaddr  = addr;
        awlen   = 8'(id);
        awsize  = 3'd2;
        awburst = burst;
        awvalid = 1'b1;
        check("awready_before_hs", awready, 1'b1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        tick();
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_b(input int n);
        for (int k = 0; k < 60 && bq.size() < n; k++) tick();
        check("b_count", bq.size(), n);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rst = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        bready = 1'b1; cmd_ready = 1'b1;
        tick(); tick(); tick();
        check("awready_in_reset", awready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_awready", awready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", pslverr, 1'b0);

        // single legal AW: cmd at N+1, B at M+1
        send_aw(4'd0, 32'h0, 2'd0);
        check("t1_cmd_valid", cmd_valid, 1'b1);
        check("t1_cmd_id", cmd_id, 4'd0);
        check("t1_cmd_addr", cmd_addr, 32'h0);
        check("t1_cmd_len", cmd_len, 8'd0);
        check("t1_bvalid_early", bvalid, 1'b0);
        tick();
        check("t1_bvalid", bvalid, 1'b1);
        check("t1_bid", bid, 4'd0);
        check("t1_bresp", bresp, 2'b00);
        check("t1_cmd_valid_after", cmd_valid, 1'b0);
        tick();
        check("t1_bvalid_done", bvalid, 1'b0);

        // out-of-window AW
        apb(1'b1, 12'h004, 32'h1000, rd, er);
        check("t2_base_err", er, 1'b0);
        apb(1'b1, 12'h008, 32'h1FFF, rd, er);
        bq.delete(); cq.delete();
        send_aw(4'd3, 32'h2000, 2'd1);
        check("t2_cmd_valid", cmd_valid, 1'b0);
        tick();
        check("t2_bvalid", bvalid, 1'b1);
        check("t2_bid", bid, 4'd3);
        check("t2_bresp", bresp, 2'b10);
        tick();
        check("t2_cmd_count", cq.size(), 0);
        apb(1'b0, 12'h010, 32'h0, rd, er);
        check("t2_err_cnt", rd, 32'd1);

        // reserved burst, then a legal AW; responses in order
        bq.delete(); cq.delete();
        send_aw(4'd4, 32'h1000, 2'd3);
        send_aw(4'd5, 32'h1800, 2'd1);
        wait_b(2);
        check("t3_b0", bq[0], {4'd4, 2'b10});
        check("t3_b1", bq[1], {4'd5, 2'b00});
        check("t3_cmd_n", cq.size(), 1);
        check("t3_cmd0", cq[0], 4'd5);
        apb(1'b0, 12'h010, 32'h0, rd, er);
        check("t3_err_cnt", rd, 32'd2);

        // fill the queue with cmd_ready low
        bq.delete(); cq.delete();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_aw(4'(6 + i), 32'h1000 + 32'(i) * 32'h10, 2'd1);
        check("t4_awready_full", awready, 1'b0);
        apb(1'b0, 12'h00C, 32'h0, rd, er);
        check("t4_status", rd, 32'h4);
        awid = 4'd10; awaddr = 32'h1100; awburst = 2'd1; awvalid = 1'b1;
        cmd_ready = 1'b1;
        #1;
        check("t4_awready_full_pop", awready, 1'b0);
        check("t4_cmd_valid_pop", cmd_valid, 1'b1);
        tick();
        check("t4_awready_after_pop", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        wait_b(5);
        for (int i = 0; i < 5; i++) check("t4_b_order", bq[i], {4'(6 + i), 2'b00});

        // B backpressure
        bq.delete(); cq.delete();
        bready = 1'b0;
        send_aw(4'd1, 32'h1000, 2'd1);
        send_aw(4'd2, 32'h1010, 2'd1);
        tick(); tick(); tick();
        check("t5_bvalid_hold", bvalid, 1'b1);
        check("t5_bid_hold", bid, 4'd1);
        check("t5_cmd_blocked", cmd_valid, 1'b0);
        apb(1'b0, 12'h00C, 32'h0, rd, er);
        check("t5_status", rd, 32'h101);
        check("t5_bid_stable", bid, 4'd1);
        bready = 1'b1;
        #1;
        check("t5_cmd_valid_release", cmd_valid, 1'b1);
        tick();
        bready = 1'b0;
        check("t5_bvalid_2", bvalid, 1'b1);
        check("t5_bid_2", bid, 4'd2);
        check("t5_bresp_2", bresp, 2'b00);
        bready = 1'b1;
        tick();
        check("t5_bvalid_done", bvalid, 1'b0);

        // APB error cases and disable
        apb(1'b0, 12'h020, 32'h0, rd, er);
        check("t6_unmapped_err", er, 1'b1);
        check("t6_unmapped_data", rd, 32'h0);
        apb(1'b1, 12'h00C, 32'hFF, rd, er);
        check("t6_status_wr_err", er, 1'b1);
        apb(1'b0, 12'h00C, 32'h0, rd, er);
        check("t6_status_unchanged", rd, 32'h0);
        check("t6_status_rd_err", er, 1'b0);
        apb(1'b1, 12'h010, 32'h0, rd, er);
        apb(1'b0, 12'h010, 32'h0, rd, er);
        check("t6_err_cnt_clear", rd, 32'h0);
        apb(1'b0, 12'h008, 32'h0, rd, er);
        check("t6_limit_rd", rd, 32'h1FFF);
        apb(1'b1, 12'h000, 32'h0, rd, er);
        check("t6_awready_disabled", awready, 1'b0);

        // reset mid-operation discards queued work
        apb(1'b1, 12'h000, 32'h1, rd, er);
        cmd_ready = 1'b0;
        bq.delete();
        send_aw(4'd11, 32'h1000, 2'd1);
        send_aw(4'd12, 32'h1000, 2'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t7_cmd_valid", cmd_valid, 1'b0);
        check("t7_bvalid", bvalid, 1'b0);
        check("t7_awready", awready, 1'b1);
        apb(1'b0, 12'h00C, 32'h0, rd, er);
        check("t7_status", rd, 32'h0);
        cmd_ready = 1'b1;
        tick(); tick(); tick();
        check("t7_no_b", bq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
